// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction channel and a
// data channel. One transaction is in flight at a time; data has fixed
// priority over inst. Each transaction moves IDLE (capture) -> ADDR
// (address phase on mem_*) -> DATA (wait for the response).
//
// Handshake: a master raises <ch>_req with a stable payload and holds both
// until <ch>_addr_ok. The address phase completes in the cycle where
// mem_req and mem_addr_ok are both high. The data phase completes in the
// cycle where mem_data_ok is high while in DATA. addr_ok/data_ok are
// single-cycle pulses and go only to the channel that owns the
// transaction. rdata is only meaningful in the cycle its data_ok is high.
module mem_arbiter (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;   // 1 = data channel, 0 = inst channel
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  // State register plus the captured request; reset aborts any transaction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      wstrb_q <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state; in IDLE pick the winner (data first) and capture its payload
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (data_req) begin
          state_d = ADDR;
          owner_d = 1'b1;
          wr_d    = data_wr;
          size_d  = data_size;
          wstrb_d = data_wstrb;
          addr_d  = data_addr;
          wdata_d = data_wdata;
        end else if (inst_req) begin
          state_d = ADDR;
          owner_d = 1'b0;
          wr_d    = inst_wr;
          size_d  = inst_size;
          wstrb_d = inst_wstrb;
          addr_d  = inst_addr;
          wdata_d = inst_wdata;
        end
      end
      ADDR:    if (mem_addr_ok) state_d = DATA;
      DATA:    if (mem_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: memory side from the captured fields, pulses steered to owner
  always_comb begin
    mem_req      = (state_q == ADDR);
    mem_wr       = wr_q;
    mem_size     = size_q;
    mem_wstrb    = wstrb_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    inst_addr_ok = (state_q == ADDR) && mem_addr_ok && !owner_q;
    data_addr_ok = (state_q == ADDR) && mem_addr_ok &&  owner_q;
    inst_data_ok = (state_q == DATA) && mem_data_ok && !owner_q;
    data_data_ok = (state_q == DATA) && mem_data_ok &&  owner_q;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    dbg_state    = state_q;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have inst-channel ports, all from the CPU side: inst_req (in, 1), inst_wr (in, 1), inst_size (in, 2), inst_wstrb (in, 4), inst_addr (in, 32) and inst_wdata (in, 32).
REQ-004 The block SHALL have inst-channel response ports: inst_addr_ok (out, 1), inst_data_ok (out, 1) and inst_rdata (out, 32).
REQ-005 The block SHALL have data-channel ports, all from the CPU side: data_req (in, 1), data_wr (in, 1), data_size (in, 2), data_wstrb (in, 4), data_addr (in, 32) and data_wdata (in, 32).
REQ-006 The block SHALL have data-channel response ports: data_addr_ok (out, 1), data_data_ok (out, 1) and data_rdata (out, 32).
REQ-007 The block SHALL have shared-memory request ports: mem_req (out, 1), mem_wr (out, 1), mem_size (out, 2), mem_wstrb (out, 4), mem_addr (out, 32) and mem_wdata (out, 32).
REQ-008 The block SHALL have shared-memory response ports: mem_addr_ok (in, 1), mem_data_ok (in, 1) and mem_rdata (in, 32).

Function
REQ-009 The block SHALL implement a state machine with three states: IDLE, ADDR and DATA.
REQ-010 In IDLE, when any req is high, the block SHALL latch the winner's wr/size/wstrb/addr/wdata and owner ID, then move to ADDR on the next cycle.
REQ-011 Arbitration SHALL use fixed priority, with data over inst; when both are high in IDLE, data SHALL win and the inst request SHALL stay pending.
REQ-012 In ADDR, mem_req SHALL be 1 and mem_* SHALL equal the latched fields, held stable until mem_addr_ok.
REQ-013 In ADDR with mem_addr_ok=1, the owner's addr_ok SHALL pulse high for exactly that cycle (combinational from mem_addr_ok), and the state SHALL move to DATA.
REQ-014 In DATA, mem_req SHALL be 0; on mem_data_ok=1, the owner's data_ok SHALL pulse that cycle, and the state SHALL return to IDLE.
REQ-015 inst_rdata and data_rdata SHALL both equal mem_rdata at all times; only the matching data_ok qualifies the value.
REQ-016 Writes (wr=1) SHALL also complete with a data_ok pulse; rdata SHALL be don't-care for writes.
REQ-017 The block SHALL allow exactly one outstanding transaction; minimum request-to-data_ok latency SHALL be 3 cycles (IDLE latch, ADDR, DATA).
REQ-018 mem_data_ok SHALL be ignored outside DATA, and mem_addr_ok SHALL be ignored outside ADDR.
REQ-019 The non-owner channel's addr_ok and data_ok SHALL be 0 at all times.
REQ-020 Upstream masters SHALL hold req and payload stable until addr_ok; a req that drops before being latched SHALL be dropped with no response.
REQ-021 After returning to IDLE, a pending request SHALL be re-arbitrated; it SHALL NOT be serviced in the same cycle that data_ok is issued.
REQ-022 The block SHALL NOT alter size or wstrb; values SHALL pass through exactly as latched.

Reset
REQ-023 While resetn=0, the state SHALL be IDLE, and mem_req, inst_addr_ok, inst_data_ok, data_addr_ok and data_data_ok SHALL be 0.
REQ-024 While resetn=0, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata and the owner register SHALL be 0.
REQ-025 Reset asserted mid-transaction (ADDR or DATA) SHALL abort the transaction immediately; a mem_data_ok arriving after resetn rises SHALL be ignored.

Verification
REQ-026 Single inst read: inst_req=1, addr=0x1C000000, mem_addr_ok=1 in ADDR, mem_data_ok one cycle later with rdata=0x02800C0C -> inst_addr_ok pulses once, inst_data_ok pulses once with inst_rdata=0x02800C0C, and data_* stays 0.
REQ-027 Simultaneous requests: inst_req=1 (0x1C000004) and data_req=1 (write 0x00000010, wstrb=0xF, wdata=0xDEADBEEF) in the same cycle -> the write is issued first with mem_wr=1, then the inst read is issued after data_data_ok.
REQ-028 Back-pressure: mem_addr_ok held 0 for 5 cycles in ADDR -> mem_req stays 1 with constant mem_addr, no addr_ok is issued, then it completes normally.
REQ-029 Spurious response: mem_data_ok=1 while in IDLE -> no data_ok is issued on either channel and the state is unchanged.
REQ-030 Reset in DATA: resetn=0 while in DATA -> all outputs are 0 the same cycle, and a later mem_data_ok produces no data_ok.
REQ-031 Byte store: data_req with size=0, addr=0x00000003, wstrb=0x8 -> mem_size=0, mem_wstrb=0x8 and mem_addr=0x00000003 are unchanged.
